// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI initiator.
//   cmd_e   : host command encoding carried in the top two frame bits
//   state_e : controller states
//   FRAME_W : serialized command frame width (2 cmd bits + 8 data bits)
//   DATA_W  : RAM byte width returned on MISO
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEL   = 3'd1,
      SHIFT = 3'd2,
      WAIT  = 3'd3,
      RECV  = 3'd4,
      END   = 3'd5
   } state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// Frame shift register: parallel load of the command frame, MSB-first
// serial out, serial in from MISO on every shift.
//   clk, rst : clock, async active-high reset
//   load     : capture par_in (takes priority over shift)
//   shift    : shift left by one, ser_in enters at bit 0
//   par_in   : frame to send
//   ser_in   : MISO
//   ser_out  : current MSB (drives MOSI through the controller)
//   rx_byte  : the byte the register will hold after one more shift; the
//              controller captures it on the final RECV edge
module spi_master_shifter
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               shift,
   input  logic [FRAME_W-1:0] par_in,
   input  logic               ser_in,
   output logic               ser_out,
   output logic [DATA_W-1:0]  rx_byte
);

   logic [FRAME_W-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (load) begin
         sreg_d = par_in;
      end else if (shift) begin
         sreg_d = {sreg_q[FRAME_W-2:0], ser_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign ser_out = sreg_q[FRAME_W-1];
   assign rx_byte = {sreg_q[DATA_W-2:0], ser_in};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: one 10-bit command frame per host request, with an 8-bit
// MISO read-back for read-data commands.
//   clk, rst             : clock, async active-high reset
//   req_valid/ready      : host request handshake (ready only in IDLE)
//   req_cmd, req_data    : command and address/data byte
//   rsp_valid, rsp_data  : read-data completion pulse and held byte
//   seq_err              : sticky command-order error
//   SS_n, MOSI, MISO     : SPI pins
//
// state | meaning
// IDLE  | SS_n high, ready for a request
// SEL   | SS_n low, MOSI shows frame[9] (slave path select)
// SHIFT | 10 cycles, frame[9..0] on MOSI
// WAIT  | TX_WAIT turnaround cycles before read-back (read-data only)
// RECV  | 8 cycles, MISO sampled MSB first
// END   | SS_n high for one cycle; read-data response presented here
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int TX_WAIT = 2
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_cmd,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              seq_err,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   cmd_e              cmd_q, cmd_d;
   logic              wr_seen_q, wr_seen_d;
   logic              rd_seen_q, rd_seen_d;
   logic              seq_err_q, seq_err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              sh_load, sh_shift, sh_out;
   logic [DATA_W-1:0] rx_byte;

   spi_master_shifter u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load    (sh_load),
      .shift   (sh_shift),
      .par_in  ({req_cmd, req_data}),
      .ser_in  (MISO),
      .ser_out (sh_out),
      .rx_byte (rx_byte)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      wr_seen_d   = wr_seen_q;
      rd_seen_d   = rd_seen_q;
      seq_err_d   = seq_err_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      sh_load     = 1'b0;
      sh_shift    = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               sh_load = 1'b1;
               cmd_d   = cmd_e'(req_cmd);
               state_d = SEL;
               case (cmd_e'(req_cmd))
                  CMD_WR_ADDR: wr_seen_d = 1'b1;
                  CMD_WR_DATA: begin
                     wr_seen_d = 1'b0;
                     if (!wr_seen_q) seq_err_d = 1'b1;
                  end
                  CMD_RD_ADDR: rd_seen_d = 1'b1;
                  default: begin
                     rd_seen_d = 1'b0;
                     if (!rd_seen_q) seq_err_d = 1'b1;
                  end
               endcase
            end
         end
         // SEL holds frame[9] without shifting, so SHIFT repeats it first.
         SEL: begin
            state_d = SHIFT;
            cnt_d   = 4'd9;
         end
         SHIFT: begin
            sh_shift = 1'b1;
            if (cnt_q == 4'd0) begin
               if (cmd_q == CMD_RD_DATA) begin
                  state_d = WAIT;
                  cnt_d   = 4'(TX_WAIT - 1);
               end else begin
                  state_d = END;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RECV;
               cnt_d   = 4'd7;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RECV: begin
            sh_shift = 1'b1;
            if (cnt_q == 4'd0) begin
               // Last bit is still on MISO; capture the completed byte now so
               // it is already valid during END.
               state_d     = END;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rx_byte;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         END: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         cmd_q       <= CMD_WR_ADDR;
         wr_seen_q   <= 1'b0;
         rd_seen_q   <= 1'b0;
         seq_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         wr_seen_q   <= wr_seen_d;
         rd_seen_q   <= rd_seen_d;
         seq_err_q   <= seq_err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign SS_n      = !((state_q == SEL) || (state_q == SHIFT) ||
                        (state_q == WAIT) || (state_q == RECV));
   assign MOSI      = ((state_q == SEL) || (state_q == SHIFT)) ? sh_out : 1'b0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
module tb_spi_master_ctrl;
   import spi_pkg::*;

   localparam int TX_WAIT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_cmd = 2'b00;
   logic [7:0] req_data = 8'h00;
   logic       MISO = 1'b0;
   logic       req_ready, rsp_valid, seq_err, SS_n, MOSI;
   logic [7:0] rsp_data;

   spi_master_ctrl #(.TX_WAIT(TX_WAIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cmd   (req_cmd),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .seq_err   (seq_err),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   // cycle index: during the cycle opened by edge A, cyc equals (value seen before A) + 1
   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [63:0] bits;
      int          len;
      int          start;
      int          gap;
      bit          err;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } rsp_t;

   frame_t frame_q[$];
   rsp_t   rsp_q[$];

   int n_chk = 0;
   int n_fail = 0;

   // reference model state
   bit         m_wr = 0, m_rd = 0, m_err = 0;
   bit         held_in = 0;
   logic [7:0] last_rsp = 8'h00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   bit          in_frame = 0;
   int          f_start = 0, f_len = 0, f_gap = 0, hi_cnt = 0;
   logic [63:0] f_bits = '0;
   bit          f_ready = 0, f_err = 0;
   frame_t      f_exp;
   rsp_t        r_exp;

   always @(negedge clk) begin
      if (rst) begin
         in_frame = 0;
         hi_cnt   = 0;
      end else begin
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rsp_unexpected: got rsp_valid with data %0h, expected no response", rsp_data);
            end else begin
               r_exp = rsp_q.pop_front();
               chk("rsp_data", 64'(rsp_data), 64'(r_exp.data));
               chk("rsp_latency", 64'(cyc - r_exp.cyc), 64'(20 + TX_WAIT));
            end
         end
         if (!SS_n) begin
            if (!in_frame) begin
               in_frame = 1;
               f_start  = cyc;
               f_len    = 0;
               f_bits   = '0;
               f_gap    = hi_cnt;
               f_ready  = 0;
               f_err    = seq_err;
            end
            f_bits = {f_bits[62:0], MOSI};
            f_len++;
            if (req_ready) f_ready = 1;
         end else if (in_frame) begin
            in_frame = 0;
            hi_cnt   = 1;
            if (frame_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL frame_unexpected: got frame of %0d cycles, expected none", f_len);
            end else begin
               f_exp = frame_q.pop_front();
               chk("frame_len", 64'(f_len), 64'(f_exp.len));
               chk("frame_bits", f_bits, f_exp.bits);
               chk("frame_start", 64'(f_start), 64'(f_exp.start));
               if (f_exp.gap >= 0) chk("frame_gap", 64'(f_gap), 64'(f_exp.gap));
               chk("frame_seq_err", 64'(f_err), 64'(f_exp.err));
               chk("ready_busy", 64'(f_ready), 64'd0);
               chk("ready_end", 64'(req_ready), 64'd0);
            end
         end else begin
            hi_cnt++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_wr = 0; m_rd = 0; m_err = 0; held_in = 0; last_rsp = 8'h00;
   endtask

   // Enters and leaves just after a rising edge.
   task automatic send(input logic [1:0] cmd, input logic [7:0] data, input bit hold, input logic [7:0] rx);
      frame_t      f;
      rsp_t        r;
      int          waited;
      logic [9:0]  fr;
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_data  = data;
      waited    = 0;
      @(negedge clk);
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready=0 for %0d cycles, expected 1", waited);
         req_valid = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      // command-order rules
      case (cmd)
         2'b00: m_wr = 1;
         2'b01: begin if (!m_wr) m_err = 1; m_wr = 0; end
         2'b10: m_rd = 1;
         default: begin if (!m_rd) m_err = 1; m_rd = 0; end
      endcase
      fr = {cmd, data};
      // SEL repeats frame[9], then the full frame; reads add idle-low MOSI for WAIT+RECV
      f.bits  = 64'({fr[9], fr});
      f.len   = 11;
      if (cmd == 2'b11) begin
         f.bits = f.bits << (TX_WAIT + 8);
         f.len  = 11 + TX_WAIT + 8;
      end
      f.start = cyc + 1;
      f.gap   = held_in ? 2 : -1;
      f.err   = m_err;
      held_in = hold;
      frame_q.push_back(f);
      if (cmd == 2'b11) begin
         r.data = rx;
         r.cyc  = cyc;
         rsp_q.push_back(r);
         last_rsp = rx;
      end
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
      if (cmd == 2'b11) begin
         // slave model: byte presented MSB first across the 8 RECV cycles
         repeat (11 + TX_WAIT) @(posedge clk);
         for (int i = 7; i >= 0; i--) begin
            #1 MISO = rx[i];
            @(posedge clk);
         end
         #1 MISO = 1'($urandom);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] c;
      logic [7:0] d, x;
      bit         h;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_ss_n", 64'(SS_n), 64'd1);
      chk("reset_mosi", 64'(MOSI), 64'd0);
      chk("reset_ready", 64'(req_ready), 64'd1);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_data", 64'(rsp_data), 64'd0);
      chk("reset_seq_err", 64'(seq_err), 64'd0);
      @(posedge clk);
      #1;

      // legal write and read sequences
      send(2'b00, 8'hA5, 0, 8'h00);
      send(2'b01, 8'h3C, 0, 8'h00);
      send(2'b10, 8'h12, 0, 8'h00);
      send(2'b11, 8'h00, 0, 8'hC3);
      idle(20);
      chk("seq_err_legal", 64'(seq_err), 64'd0);

      // out-of-order write data straight after reset
      do_reset();
      send(2'b01, 8'h55, 0, 8'h00);
      send(2'b00, 8'h10, 0, 8'h00);
      send(2'b01, 8'h20, 0, 8'h00);
      idle(20);
      chk("seq_err_sticky", 64'(seq_err), 64'd1);

      // reset in the middle of SHIFT
      req_valid = 1'b1;
      req_cmd   = 2'b00;
      req_data  = 8'h5A;
      @(negedge clk);
      chk("abort_ready_before", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_ss_n", 64'(SS_n), 64'd1);
      chk("abort_mosi", 64'(MOSI), 64'd0);
      chk("abort_ready", 64'(req_ready), 64'd1);
      chk("abort_seq_err", 64'(seq_err), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      m_wr = 0; m_rd = 0; m_err = 0; held_in = 0; last_rsp = 8'h00;
      @(negedge clk);
      chk("abort_ready_after", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      send(2'b10, 8'h01, 0, 8'h00);
      idle(20);

      // back-to-back with req_valid held
      send(2'b00, 8'h11, 1, 8'h00);
      send(2'b01, 8'h22, 1, 8'h00);
      send(2'b00, 8'h33, 0, 8'h00);
      idle(20);

      // randomized traffic
      for (int k = 0; k < 30; k++) begin
         c = 2'($urandom_range(0, 3));
         d = 8'($urandom);
         x = 8'($urandom);
         h = (k < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
         send(c, d, h, x);
         if (!h) idle($urandom_range(0, 3));
      end
      idle(40);

      chk("frames_drained", 64'(frame_q.size()), 64'd0);
      chk("rsps_drained", 64'(rsp_q.size()), 64'd0);
      chk("rsp_data_held", 64'(rsp_data), 64'(last_rsp));
      chk("seq_err_final", 64'(seq_err), 64'(m_err));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

SPI initiator that drives the SPI slave / single-port RAM subsystem from a simple host request/response interface. It serializes one 10-bit command word per request (2 command bits + 8 data bits) onto MOSI under SS_n. For read-data commands it also deserializes the 8-bit RAM byte returned on MISO. It sits between the system host (or testbench sequencer) and the SPI slave, on the same clock.

## Interface
- TX_WAIT, 2: MISO turnaround cycles after the last MOSI bit of a read-data frame, before the first MISO sample (1..15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  block idle and able to accept a request.
- req_cmd  in  2  00 write address, 01 write data, 10 read address, 11 read data.
- req_data  in  8  address or data byte; ignored for 11.
- rsp_valid  out  1  one-cycle pulse when a read-data frame completes.
- rsp_data  out  8  byte received on MISO; held until the next rsp_valid.
- seq_err  out  1  sticky protocol-order error flag; cleared only by rst.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

## Operation
- Request accepted on a rising edge with req_valid && req_ready. The block latches frame = {req_cmd, req_data} (10 bits).
- States:
  - IDLE: SS_n=1, MOSI=0, req_ready=1. Goes to SEL on accept.
  - SEL (1 cycle): SS_n=0, MOSI=frame[9]. This is the slave's write/read path-select bit.
  - SHIFT (10 cycles): MOSI=frame[9] down to frame[0], MSB first.
  - After SHIFT: cmd≠11 goes to END; cmd=11 goes to WAIT.
  - WAIT (TX_WAIT cycles): SS_n=0, MOSI=0.
  - RECV (8 cycles): MISO sampled each edge, MSB first, into the shift register.
  - END (1 cycle): SS_n=1, MOSI=0, req_ready=0. For 11, rsp_valid=1 and rsp_data updated in this cycle. Then goes to IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored and does not queue.
- Bit counter: 4 bits, reloaded on each state entry, terminal count 0.
- Order tracking:
  - wr_addr_seen is set by cmd 00 and cleared by cmd 01.
  - rd_addr_seen is set by cmd 10 and cleared by cmd 11.
  - cmd 01 without wr_addr_seen, or cmd 11 without rd_addr_seen, sets seq_err at accept. The frame is still sent.
- Back-to-back requests: with req_valid held high, the next accept occurs on the IDLE cycle after END. SS_n is therefore high for at least 2 cycles between frames.

## Timing
- Reset values: SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_data=8'h00, seq_err=0. State is IDLE and both seen-flags are clear.
- rst mid-frame: outputs go to reset values immediately (asynchronous). The frame is abandoned and no rsp_valid is produced.
- Accept at edge A:
  - SS_n falls after A.
  - SEL occupies cycle A+1; SHIFT occupies cycles A+2..A+11.
  - For cmd≠11, END is cycle A+12, IDLE is A+13, and busy time is 12 cycles.
- cmd=11:
  - WAIT occupies A+12..A+11+TX_WAIT.
  - RECV occupies the next 8 cycles.
  - END carries rsp_valid. Busy time is 20+TX_WAIT cycles; 22 at default.
- MISO is sampled on the rising edge closing each RECV cycle. Bit 7 comes from the first RECV cycle.
- rsp_data is registered; it is never combinational from MISO.

## Structure
- Package spi_pkg holds:
  - cmd_e enum: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - state_e enum: IDLE, SEL, SHIFT, WAIT, RECV, END.
  - localparams FRAME_W=10 and DATA_W=8.
- One sub-module, spi_master_shifter:
  - 10-bit parallel-load, MSB-out shift register with serial-in for MISO capture.
  - Controlled by load/shift enables from the FSM.
- The FSM, counter and order flags live in spi_master_ctrl.

## Test plan
- Reset then idle 5 cycles → SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, seq_err=0.
- Send 00/8'hA5, then 01/8'h3C → MOSI streams 1'b0 then 10'b00_1010_0101, then 1'b0 then 10'b01_0011_1100. SS_n is low for exactly 11 cycles each. seq_err stays 0.
- Send 10/8'h12, then 11 with a MISO model driving 8'hC3 after TX_WAIT=2 → rsp_valid pulses once, 22 cycles after the second accept, with rsp_data=8'hC3.
- Send 01/8'h55 directly after reset → frame sent normally and seq_err=1 from the next cycle. seq_err stays 1 through later legal frames.
- Assert rst during SHIFT bit 4 of a 00 frame → SS_n=1 in the same cycle and req_ready=1 after release. A following 10/8'h01 frame completes cleanly.
- Hold req_valid high for three writes → no request is dropped, SS_n is high for exactly 2 cycles between frames, and req_ready=0 throughout each frame.
